control_mode_fsm: RTL and testbench

//  Parametrised mode selector for the player front panel. A mode button steps

---
 rtl/control_mode_fsm_pkg.sv | 16 +
 rtl/control_mode_fsm_rise_detect.sv | 22 ++
 rtl/control_mode_fsm.sv | 142 ++++++++++++++
 tb/tb_control_mode_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/control_mode_fsm_pkg.sv
// Shared types for the front-panel mode selector: action FSM states and mode index names.
package control_mode_fsm_pkg;

    typedef enum logic [1:0] {
        ACT_IDLE   = 2'd0,
        ACT_HELD   = 2'd1,
        ACT_REPEAT = 2'd2
    } act_state_e;

    localparam int MODE_RESET   = 0;
    localparam int MODE_NEXT    = 1;
    localparam int MODE_REWIND  = 2;
    localparam int MODE_FF      = 3;
    localparam int MODE_DISPLAY = 4;

endpackage

// File: rtl/control_mode_fsm_rise_detect.sv
// Registered rising-edge detector; the history flop resets high so a level held
// through reset never reads as a fresh press.
module control_mode_fsm_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic rise_o
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= in_i;
        end
    end

    assign rise_o = in_i & ~hist_q;

endmodule

// File: rtl/control_mode_fsm.sv
// Front-panel mode selector: steps through NUM_MODES modes and routes the shared
// action button to the owning mode as a level plus press/auto-repeat pulses.
module control_mode_fsm
    import control_mode_fsm_pkg::*;
#(
    parameter int                     NUM_MODES     = 5,
    parameter int                     MODE_W        = 3,
    parameter int                     REPEAT_DELAY  = 50_000_000,
    parameter int                     REPEAT_PERIOD = 10_000_000,
    parameter int                     CNT_W         = 26,
    parameter logic [NUM_MODES-1:0]   REPEAT_MASK   = 5'b01100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode_btn,
    input  logic                  mode_back,
    input  logic                  action_btn,
    output logic [MODE_W-1:0]     mode,
    output logic [NUM_MODES-1:0]  mode_onehot,
    output logic [NUM_MODES-1:0]  action_level,
    output logic [NUM_MODES-1:0]  action_pulse,
    output logic                  mode_changed
);

    localparam logic [MODE_W-1:0] LAST_MODE   = MODE_W'(NUM_MODES - 1);
    localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    function automatic logic [NUM_MODES-1:0] to_onehot(input logic [MODE_W-1:0] idx);
        return NUM_MODES'(1) << idx;
    endfunction

    logic mode_rise, back_rise, act_rise;

    control_mode_fsm_rise_detect u_mode_rise (
        .clk(clk), .reset(reset), .in_i(mode_btn), .rise_o(mode_rise)
    );
    control_mode_fsm_rise_detect u_back_rise (
        .clk(clk), .reset(reset), .in_i(mode_back), .rise_o(back_rise)
    );
    control_mode_fsm_rise_detect u_act_rise (
        .clk(clk), .reset(reset), .in_i(action_btn), .rise_o(act_rise)
    );

    logic [MODE_W-1:0]    mode_q, mode_d;
    logic                 changed_q, changed_d;
    act_state_e           state_q, state_d;
    logic [MODE_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_MODES-1:0] level_q, level_d;
    logic [NUM_MODES-1:0] pulse_q, pulse_d;
    logic                 rep_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= '0;
            changed_q <= 1'b0;
            state_q   <= ACT_IDLE;
            owner_q   <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            changed_q <= changed_d;
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
        end
    end

    // Opposing presses in the same cycle cancel out.
    always_comb begin
        mode_d    = mode_q;
        changed_d = 1'b0;
        if (mode_rise && !back_rise) begin
            mode_d    = (mode_q == LAST_MODE) ? '0 : mode_q + MODE_W'(1);
            changed_d = 1'b1;
        end else if (back_rise && !mode_rise) begin
            mode_d    = (mode_q == '0) ? LAST_MODE : mode_q - MODE_W'(1);
            changed_d = 1'b1;
        end
    end

    assign rep_en = |(REPEAT_MASK & to_onehot(owner_q));

    // Owner is latched from the pre-change mode register, so a concurrent mode
    // press never steals the action.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        if (!action_btn) begin
            state_d = ACT_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACT_IDLE: begin
                    if (act_rise) begin
                        state_d = ACT_HELD;
                        owner_d = mode_q;
                        cnt_d   = '0;
                        pulse_d = to_onehot(mode_q);
                    end
                end
                ACT_HELD: begin
                    if (rep_en && cnt_q == DELAY_LAST) begin
                        state_d = ACT_REPEAT;
                        cnt_d   = '0;
                        pulse_d = to_onehot(owner_q);
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ACT_REPEAT: begin
                    if (cnt_q == PERIOD_LAST) begin
                        cnt_d   = '0;
                        pulse_d = to_onehot(owner_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ACT_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        level_d = (state_d != ACT_IDLE) ? to_onehot(owner_d) : '0;
    end

    assign mode         = mode_q;
    assign mode_onehot  = to_onehot(mode_q);
    assign action_level = level_q;
    assign action_pulse = pulse_q;
    assign mode_changed = changed_q;

endmodule

// File: tb/tb_control_mode_fsm.sv
// Bench for control_mode_fsm: directed panel scenarios followed by random button
// activity, all compared against a cycle-level behavioural model.
module tb_control_mode_fsm;

    localparam int         N    = 5;
    localparam int         RD   = 8;
    localparam int         RP   = 3;
    localparam logic [4:0] MASK = 5'b01100;

    logic       clk = 1'b0;
    logic       reset, mode_btn, mode_back, action_btn;
    logic [2:0] mode;
    logic [4:0] mode_onehot, action_level, action_pulse;
    logic       mode_changed;

    always #5 clk = ~clk;

    control_mode_fsm #(
        .NUM_MODES(5), .MODE_W(3), .REPEAT_DELAY(8), .REPEAT_PERIOD(3),
        .CNT_W(4), .REPEAT_MASK(5'b01100)
    ) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .mode_back(mode_back),
        .action_btn(action_btn), .mode(mode), .mode_onehot(mode_onehot),
        .action_level(action_level), .action_pulse(action_pulse),
        .mode_changed(mode_changed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: age counts cycles since the accepted press.
    int         m_mode, owner, age;
    bit         p_mb, p_bk, p_ab, active;
    logic [4:0] e_level, e_pulse;
    logic       e_changed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; owner = 0; age = 0; active = 0;
        p_mb = 1; p_bk = 1; p_ab = 1;
        e_level = '0; e_pulse = '0; e_changed = 1'b0;
    endtask

    task automatic model_edge(input bit mb, input bit bk, input bit ab);
        bit rm, rb, ra;
        int old;
        rm = mb && !p_mb;
        rb = bk && !p_bk;
        ra = ab && !p_ab;
        old = m_mode;
        e_changed = rm ^ rb;
        if (rm && !rb)      m_mode = (m_mode + 1) % N;
        else if (rb && !rm) m_mode = (m_mode + N - 1) % N;
        if (!ab) active = 0;
        else if (!active) begin
            if (ra) begin active = 1; owner = old; age = 0; end
        end else age++;
        e_level = active ? 5'(1 << owner) : 5'b0;
        e_pulse = (active && (age == 0 || (MASK[owner] && age >= RD && (age - RD) % RP == 0)))
                  ? 5'(1 << owner) : 5'b0;
        p_mb = mb; p_bk = bk; p_ab = ab;
    endtask

    task automatic check_all();
        chk("mode",         32'(mode),         32'(m_mode));
        chk("mode_onehot",  32'(mode_onehot),  32'(1 << m_mode));
        chk("action_level", 32'(action_level), 32'(e_level));
        chk("action_pulse", 32'(action_pulse), 32'(e_pulse));
        chk("mode_changed", 32'(mode_changed), 32'(e_changed));
    endtask

    task automatic step(input bit mb, input bit bk, input bit ab);
        mode_btn = mb; mode_back = bk; action_btn = ab;
        @(posedge clk);
        model_edge(mb, bk, ab);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit mb, input bit bk, input bit ab);
        reset = 1'b1; mode_btn = mb; mode_back = bk; action_btn = ab;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        int          t1_exp[6];
        int          n_chg, lv, cnt;
        logic [31:0] pat;
        bit          mb_s, bk_s, ab_s;

        t1_exp = '{1, 2, 3, 4, 0, 1};
        reset = 1'b1; mode_btn = 1'b0; mode_back = 1'b0; action_btn = 1'b0;
        model_reset();
        do_reset(0, 0, 0);
        do_reset(0, 0, 0);
        step(0, 0, 0);

        // 1: six forward presses wrap 4 -> 0
        n_chg = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            chk("t1_mode", 32'(mode), 32'(t1_exp[i]));
            n_chg += int'(mode_changed);
            step(0, 0, 0);
            n_chg += int'(mode_changed);
        end
        chk("t1_changed_cnt", 32'(n_chg), 32'd6);

        // 2: back from mode 0 wraps to 4
        for (int i = 0; i < 4; i++) begin step(1, 0, 0); step(0, 0, 0); end
        chk("t2_mode0", 32'(mode), 32'd0);
        step(0, 1, 0);
        chk("t2_mode", 32'(mode), 32'd4);
        chk("t2_onehot", 32'(mode_onehot), 32'b10000);
        step(0, 0, 0);

        // 3: repeat-enabled mode 3, 20-cycle hold
        step(0, 1, 0); step(0, 0, 0);
        chk("t3_mode", 32'(mode), 32'd3);
        pat = '0; lv = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1);
            pat[k] = action_pulse[3];
            if (action_level == 5'b01000) lv++;
        end
        chk("t3_pulse_pattern", pat, 32'h24901);
        chk("t3_level_cycles", 32'(lv), 32'd20);
        step(0, 0, 0);
        chk("t3_release_level", 32'(action_level), 32'd0);

        // 4: mode 1 has no repeat
        step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 1);
            cnt += int'(action_pulse[1]);
        end
        chk("t4_pulse_count", 32'(cnt), 32'd1);
        step(0, 0, 0);

        // 5: ownership stays with mode 2 across a mode change
        step(1, 0, 0); step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(1, 0, 1); step(0, 0, 1);
        chk("t5_mode", 32'(mode), 32'd3);
        chk("t5_level", 32'(action_level), 32'b00100);
        step(0, 0, 0);
        chk("t5_release_level", 32'(action_level), 32'd0);

        // 6: simultaneous rise, then reset mid-hold
        step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
        step(1, 0, 1);
        chk("t6_pulse", 32'(action_pulse), 32'b00010);
        chk("t6_mode", 32'(mode), 32'd2);
        step(0, 0, 1); step(0, 0, 1);
        do_reset(0, 0, 1);
        chk("t6_rst_level", 32'(action_level), 32'd0);
        chk("t6_rst_mode", 32'(mode), 32'd0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1);
            cnt += int'(|action_pulse) + int'(|action_level);
        end
        chk("t6_held_after_reset", 32'(cnt), 32'd0);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("t6_repress_pulse", 32'(action_pulse), 32'b00001);
        step(0, 0, 0);

        // random button activity
        mb_s = 0; bk_s = 0; ab_s = 0;
        for (int i = 0; i < 800; i++) begin
            mb_s ^= ($urandom_range(0, 3) == 0);
            bk_s ^= ($urandom_range(0, 5) == 0);
            ab_s ^= ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) do_reset(mb_s, bk_s, ab_s);
            else                             step(mb_s, bk_s, ab_s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
